// File: rtl/cfg_bus_arbiter.sv
// cfg_bus_arbiter: round-robin two-port arbiter and sequencer for the shared 4-bit config register bus.
// Define CFG_ARB_TIMEOUT_EN to abort transactions that no slave acks within TIMEOUT_CYCLES.
module cfg_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_addr,
    input  logic [3:0] req0_data,
    input  logic       req1_valid,
    input  logic [3:0] req1_addr,
    input  logic [3:0] req1_data,
    output logic       req0_done,
    output logic       req1_done,
    output logic       req_timeout,
    output logic [3:0] rdata,
    output logic       rdata_valid,
    output logic [3:0] bus_address,
    output logic [3:0] bus_data,
    output logic       bus_valid,
    input  logic       bus_ack,
    input  logic [3:0] bus_data_out,
    input  logic       bus_data_out_valid
);
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
    state_t     state_q, state_d;
    logic       last_q, last_d, gnt_q, gnt_d, fresh_q, fresh_d, valid_q, valid_d;
    logic       done0_q, done0_d, done1_q, done1_d, tmo_q, tmo_d, rvalid_q, rvalid_d;
    logic [3:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
    logic       pick, expire;
    // On contention the port not granted last time wins; a lone requester always wins.
    assign pick = (req0_valid && req1_valid) ? ~last_q : req1_valid;
`ifdef CFG_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    assign cnt_d  = (state_q == BUSY) ? cnt_q + 8'd1 : 8'd0;
    assign expire = (state_q == BUSY) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 8'd0;
        else      cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        rdata_d  = rdata_q;
        fresh_d  = fresh_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        tmo_d    = 1'b0;
        rvalid_d = 1'b0;
        case (state_q)
            IDLE: if (req0_valid || req1_valid) begin
                gnt_d   = pick;
                last_d  = pick;
                addr_d  = pick ? req1_addr : req0_addr;
                data_d  = pick ? req1_data : req0_data;
                valid_d = 1'b1;
                fresh_d = 1'b0;
                state_d = BUSY;
            end
            BUSY: begin
                if (bus_data_out_valid) begin
                    rdata_d = bus_data_out;
                    fresh_d = 1'b1;
                end
                if (bus_ack || expire) begin
                    valid_d  = 1'b0;
                    done0_d  = ~gnt_q;
                    done1_d  = gnt_q;
                    tmo_d    = ~bus_ack;
                    rvalid_d = bus_ack && (fresh_q || bus_data_out_valid);
                    fresh_d  = 1'b0;
                    state_d  = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            addr_q   <= 4'd0;
            data_q   <= 4'd0;
            valid_q  <= 1'b0;
            rdata_q  <= 4'd0;
            fresh_q  <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            tmo_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
            fresh_q  <= fresh_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            tmo_q    <= tmo_d;
            rvalid_q <= rvalid_d;
        end
    end
    assign req0_done   = done0_q;
    assign req1_done   = done1_q;
    assign req_timeout = tmo_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign bus_address = addr_q;
    assign bus_data    = data_q;
    assign bus_valid   = valid_q;
endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// tb_cfg_bus_arbiter: directed and randomized checks of cfg_bus_arbiter against a transaction-level model.
module tb_cfg_bus_arbiter;
    logic       clk = 1'b0, rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_addr = 4'd0, req0_data = 4'd0, req1_addr = 4'd0, req1_data = 4'd0;
    logic       bus_ack = 1'b0, bus_data_out_valid = 1'b0;
    logic [3:0] bus_data_out = 4'd0;
    logic       req0_done, req1_done, req_timeout, rdata_valid, bus_valid;
    logic [3:0] rdata, bus_address, bus_data;
    int         checks = 0, errors = 0;
    bit         pend0 = 0, pend1 = 0, m_last = 1;
    logic [3:0] pa0 = 0, pd0 = 0, pa1 = 0, pd1 = 0, m_rdata = 0;

    always #5 clk = ~clk;

    cfg_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req0_done(req0_done), .req1_done(req1_done), .req_timeout(req_timeout),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .bus_address(bus_address), .bus_data(bus_data), .bus_valid(bus_valid),
        .bus_ack(bus_ack), .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit p, input logic [3:0] a, input logic [3:0] d);
        if (p) begin
            req1_valid = 1; req1_addr = a; req1_data = d; pa1 = a; pd1 = d; pend1 = 1;
        end else begin
            req0_valid = 1; req0_addr = a; req0_data = d; pa0 = a; pd0 = d; pend0 = 1;
        end
    endtask

    task automatic drop(input bit p);
        if (p) begin req1_valid = 0; pend1 = 0; end
        else begin req0_valid = 0; pend0 = 0; end
    endtask

    // Model: winner is the lone requester, or the port not served last when both wait.
    function automatic bit winner();
        return (pend0 && pend1) ? ~m_last : pend1;
    endfunction

    // rd_mode: 0 no read-back, 1 read-back with the ack, 2 read-back in the first BUSY cycle.
    task automatic serve(input bit gap_first, input int d, input int rd_mode, input logic [3:0] rv, input bit stray);
        bit w;
        logic [3:0] ea, ed;
        if (gap_first) begin
            bus_ack = stray;
            tick;
            bus_ack = 0;
            chk("gap_valid", bus_valid, 0);
            chk("gap_done", {req1_done, req0_done}, 0);
        end
        w  = winner();
        ea = w ? pa1 : pa0;
        ed = w ? pd1 : pd0;
        tick;
        chk("grant_valid", bus_valid, 1);
        chk("grant_addr", bus_address, ea);
        chk("grant_data", bus_data, ed);
        for (int i = 0; i < d; i++) begin
            if (rd_mode == 2 && i == 0) begin
                bus_data_out = rv; bus_data_out_valid = 1; m_rdata = rv;
            end
            tick;
            bus_data_out_valid = 0; bus_data_out = 0;
            chk("hold_valid", bus_valid, 1);
            chk("hold_addr", bus_address, ea);
            chk("hold_done", {req1_done, req0_done}, 0);
        end
        if (rd_mode == 1 || (rd_mode == 2 && d == 0)) begin
            bus_data_out = rv; bus_data_out_valid = 1; m_rdata = rv;
        end
        bus_ack = 1;
        tick;
        bus_ack = 0; bus_data_out_valid = 0; bus_data_out = 0;
        chk("done", {req1_done, req0_done}, w ? 2 : 1);
        chk("ack_valid", bus_valid, 0);
        chk("ack_timeout", req_timeout, 0);
        chk("rdata_valid", rdata_valid, rd_mode != 0);
        chk("rdata", rdata, m_rdata);
        drop(w);
        m_last = w;
    endtask

    initial begin
        bit w;
        int bad;
        tick;
        tick;
        chk("rst_valid", bus_valid, 0);
        chk("rst_addr", bus_address, 0);
        chk("rst_data", bus_data, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_pulses", {req_timeout, rdata_valid, req1_done, req0_done}, 0);
        rst = 1;
        tick;
        bus_ack = 1;
        tick;
        bus_ack = 0;
        chk("stray_done", {req1_done, req0_done}, 0);
        chk("stray_valid", bus_valid, 0);
        tick;
        chk("stray_idle", bus_valid, 0);
        // Tie from reset: port 0 first, then port 1 with a read-back at the ack.
        set_req(0, 4'h3, 4'hA);
        set_req(1, 4'h5, 4'hC);
        serve(0, 1, 0, 4'h0, 0);
        serve(1, 0, 1, 4'h7, 0);
        set_req(1, 4'hE, 4'h2);
        tick;
        chk("to_gap", bus_valid, 0);
        tick;
        w = winner();
        chk("to_grant", bus_address, 4'hE);
`ifdef CFG_ARB_TIMEOUT_EN
        bus_data_out = 4'h5; bus_data_out_valid = 1; m_rdata = 4'h5;
        tick;
        bus_data_out = 0; bus_data_out_valid = 0;
        chk("to_hold1", {bus_valid, req_timeout, req1_done}, 3'b100);
        tick;
        chk("to_hold2", {bus_valid, req_timeout, req1_done}, 3'b100);
        tick;
        chk("to_hold3", {bus_valid, req_timeout, req1_done}, 3'b100);
        tick;
        chk("to_done", {req1_done, req0_done}, w ? 2 : 1);
        chk("to_pulse", req_timeout, 1);
        chk("to_rvalid", rdata_valid, 0);
        chk("to_valid", bus_valid, 0);
        chk("to_rdata", rdata, m_rdata);
`else
        bad = 0;
        repeat (1000) begin
            tick;
            if (bus_valid !== 1'b1 || req0_done || req1_done || req_timeout) bad++;
        end
        chk("no_to_hold", bad, 0);
        bus_ack = 1;
        tick;
        bus_ack = 0;
        chk("no_to_done", {req1_done, req0_done}, w ? 2 : 1);
        chk("no_to_pulse", req_timeout, 0);
`endif
        drop(w);
        m_last = w;
        for (int t = 0; t < 60; t++) begin
            if (!pend0 && $urandom_range(0, 1) == 1) set_req(0, 4'($urandom), 4'($urandom));
            if (!pend1 && $urandom_range(0, 1) == 1) set_req(1, 4'($urandom), 4'($urandom));
            if (!pend0 && !pend1) set_req(1'($urandom), 4'($urandom), 4'($urandom));
            serve(1, $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom), 1'($urandom));
        end
        // Asynchronous reset in the middle of a granted transaction.
        drop(0);
        drop(1);
        set_req(1, 4'h9, 4'h6);
        tick;
        tick;
        chk("mid_grant", {bus_valid, bus_address}, 5'h19);
        #2;
        rst = 0;
        #1;
        chk("mid_rst_valid", bus_valid, 0);
        chk("mid_rst_bus", {bus_address, bus_data, rdata}, 0);
        chk("mid_rst_pulses", {req_timeout, rdata_valid, req1_done, req0_done}, 0);
        m_last = 1;
        m_rdata = 0;
        tick;
        chk("mid_rst_nodone", {req1_done, req0_done, bus_valid}, 0);
        rst = 1;
        serve(0, 1, 0, 4'h0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
